// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for coprocessor 0 and the pipeline stage registers.
//   - CP0 register indices (SR, Cause, EPC, PRId)
//   - SR / Cause field bit positions
//   - HANDLER_ADDR: exception entry point used by the stage registers on flush
//   - MIPS exception codes carried down the pipe in ExcCode
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR fields
  localparam int SR_IE_BIT = 0;
  localparam int SR_EXL_BIT = 1;
  localparam int SR_IM_LO = 10;
  localparam int SR_IM_HI = 15;

  // Cause fields
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO = 10;
  localparam int CAUSE_IP_HI = 15;
  localparam int CAUSE_BD_BIT = 31;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  // Word-aligned EPC for the faulting instruction; a delay-slot fault
  // restarts at the branch, one word earlier (wraps modulo 2^32).
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    logic [31:0] aligned;
    aligned = {pc[31:2], 2'b00};
    return bd ? aligned - 32'd4 : aligned;
  endfunction

endpackage

// File: rtl/cp0.sv
// cp0: coprocessor 0 at the M stage. Merges per-instruction exception
// metadata with external interrupts, raises Req (flush + redirect to the
// handler), and holds SR, Cause, EPC and PRId for mfc0/mtc0/eret.
//
// Ports:
//   clk        clock, all state changes on posedge
//   reset      synchronous, active-high; clears SR, Cause, EPC
//   A1         mfc0 read index          -> DOut (combinational)
//   A2/DIn/WE  mtc0 write index/data/enable (SR and EPC writable)
//   EXLClr     eret in M: clears SR.EXL
//   PC         M-stage PC
//   BDIn       M-stage instruction sits in a branch delay slot
//   ExcCodeIn  M-stage pending exception code, 0 = none
//   HWInt      level-sensitive interrupt lines
//   Req        take exception/interrupt this cycle (combinational)
//   EPCOut     current EPC for eret redirection
//   DOut       mfc0 read data
module cp0 #(
  parameter logic [31:0] PRID_VALUE   = 32'h0000_0007,
  parameter logic [31:0] HANDLER_ADDR = cp0_pkg::HANDLER_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic        EXLClr,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  output logic        Req,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);

  import cp0_pkg::*;

  logic [5:0]  r_sr_im;
  logic        r_sr_exl;
  logic        r_sr_ie;
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip;
  logic [4:0]  r_cause_exc;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic [31:0] w_dout;
  logic        w_unused_bits;

  // EXL masks both sources; interrupts additionally need IE and a matching IM bit.
  assign w_int_req = (|(HWInt & r_sr_im)) & r_sr_ie & ~r_sr_exl;
  assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_sr_exl;
  assign w_req     = w_int_req | w_exc_req;

  assign w_sr    = {16'b0, r_sr_im, 8'b0, r_sr_exl, r_sr_ie};
  assign w_cause = {r_cause_bd, 15'b0, r_cause_ip, 3'b0, r_cause_exc, 2'b00};

  always_comb begin
    w_dout = 32'b0;
    case (A1)
      REG_SR:    w_dout = w_sr;
      REG_CAUSE: w_dout = w_cause;
      REG_EPC:   w_dout = r_epc;
      REG_PRID:  w_dout = PRID_VALUE;
      default:   w_dout = 32'b0;
    endcase
  end

  // Priority: reset > Req > EXLClr > WE. A write in a Req cycle is dropped so
  // the captured EPC/EXL cannot be overwritten by the faulting instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr_im     <= '0;
      r_sr_exl    <= 1'b0;
      r_sr_ie     <= 1'b0;
      r_cause_bd  <= 1'b0;
      r_cause_ip  <= '0;
      r_cause_exc <= '0;
      r_epc       <= '0;
    end else begin
      r_cause_ip <= HWInt;
      if (w_req) begin
        r_sr_exl    <= 1'b1;
        r_cause_bd  <= BDIn;
        r_cause_exc <= w_int_req ? EXC_INT : ExcCodeIn;
        r_epc       <= epc_of(PC, BDIn);
      end else if (EXLClr) begin
        r_sr_exl <= 1'b0;
      end else if (WE) begin
        case (A2)
          REG_SR: begin
            r_sr_im  <= DIn[SR_IM_HI:SR_IM_LO];
            r_sr_exl <= DIn[SR_EXL_BIT];
            r_sr_ie  <= DIn[SR_IE_BIT];
          end
          REG_EPC: r_epc <= DIn;
          default: ;
        endcase
      end
    end
  end

  assign Req    = w_req;
  assign EPCOut = r_epc;
  assign DOut   = w_dout;

  // Bits that carry no state here; HANDLER_ADDR is consumed by the stage registers.
  assign w_unused_bits = ^{DIn[31:16], DIn[9:2], HANDLER_ADDR};

endmodule

// File: tb/tb_cp0.sv
module tb_cp0;
  import cp0_pkg::*;

  localparam logic [31:0] PRID = 32'h0000_0007;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, ExcCodeIn;
  logic [31:0] DIn, PC;
  logic        WE, EXLClr, BDIn;
  logic [5:0]  HWInt;
  logic        Req;
  logic [31:0] EPCOut, DOut;

  cp0 #(.PRID_VALUE(PRID), .HANDLER_ADDR(32'h0000_4180)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .EXLClr(EXLClr), .PC(PC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
    .HWInt(HWInt), .Req(Req), .EPCOut(EPCOut), .DOut(DOut)
  );

  always #10 clk = ~clk;

  // kind: 0 = DOut at index a1, 1 = Req, 2 = EPCOut
  typedef struct {
    string       name;
    int          kind;
    logic [4:0]  a1;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic push(input string name, input int kind, input logic [4:0] a1, input logic [31:0] val);
    exp_t e;
    e.name = name; e.kind = kind; e.a1 = a1; e.val = val;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; WE = 1'b0; EXLClr = 1'b0;
    PC = 32'd0; BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    HWInt = 6'h3F;
    tick();
    reset = 1'b0;
    push("rst_sr", 0, REG_SR, 32'h0);
    push("rst_cause", 0, REG_CAUSE, 32'h0);
    push("rst_epc", 0, REG_EPC, 32'h0);
    push("rst_prid", 0, REG_PRID, PRID);
    push("rst_other", 0, 5'd3, 32'h0);
    push("rst_req_masked", 1, 5'd0, 32'h0);
    push("rst_epcout", 2, 5'd0, 32'h0);
    while (sb.size() > 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      A1 = e.a1; #1;
      obs = (e.kind == 0) ? DOut : (e.kind == 1) ? {31'b0, Req} : EPCOut;
      n_checks++;
      if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      else n_pass++;
    end
    tick();
    push("rst_ip_follows_hwint", 0, REG_CAUSE, 32'h0000_FC00);
    push("rst_req_still_masked", 1, 5'd0, 32'h0);
    while (sb.size() > 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      A1 = e.a1; #1;
      obs = (e.kind == 0) ? DOut : (e.kind == 1) ? {31'b0, Req} : EPCOut;
      n_checks++;
      if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      else n_pass++;
    end
    HWInt = 6'd0;
    tick();
  endtask

  task automatic test_interrupt();
    idle_inputs();
    WE = 1'b1; A2 = REG_SR; DIn = 32'h0000_0401;
    push("mtc0_not_bypassed", 0, REG_SR, 32'h0);
    while (sb.size() > 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      A1 = e.a1; #1;
      obs = (e.kind == 0) ? DOut : (e.kind == 1) ? {31'b0, Req} : EPCOut;
      n_checks++;
      if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      else n_pass++;
    end
    tick();
    WE = 1'b0;
    HWInt = 6'b000001; PC = 32'h0000_3010;
    push("sr_written", 0, REG_SR, 32'h0000_0401);
    push("int_req", 1, 5'd0, 32'h1);
    while (sb.size() > 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      A1 = e.a1; #1;
      obs = (e.kind == 0) ? DOut : (e.kind == 1) ? {31'b0, Req} : EPCOut;
      n_checks++;
      if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      else n_pass++;
    end
    tick();
    push("int_sr_exl", 0, REG_SR, 32'h0000_0403);
    push("int_cause", 0, REG_CAUSE, 32'h0000_0400);
    push("int_epc", 0, REG_EPC, 32'h0000_3010);
    push("int_epcout", 2, 5'd0, 32'h0000_3010);
    push("int_req_masked", 1, 5'd0, 32'h0);
    while (sb.size() > 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      A1 = e.a1; #1;
      obs = (e.kind == 0) ? DOut : (e.kind == 1) ? {31'b0, Req} : EPCOut;
      n_checks++;
      if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      else n_pass++;
    end
    EXLClr = 1'b1; HWInt = 6'd0;
    tick();
    EXLClr = 1'b0;
    push("eret_sr", 0, REG_SR, 32'h0000_0401);
    push("eret_req_idle", 1, 5'd0, 32'h0);
    while (sb.size() > 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      A1 = e.a1; #1;
      obs = (e.kind == 0) ? DOut : (e.kind == 1) ? {31'b0, Req} : EPCOut;
      n_checks++;
      if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      else n_pass++;
    end
  endtask

  task automatic test_exception_bd();
    idle_inputs();
    ExcCodeIn = EXC_OV; BDIn = 1'b1; PC = 32'h0000_3024;
    push("ov_req", 1, 5'd0, 32'h1);
    while (sb.size() > 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      A1 = e.a1; #1;
      obs = (e.kind == 0) ? DOut : (e.kind == 1) ? {31'b0, Req} : EPCOut;
      n_checks++;
      if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      else n_pass++;
    end
    tick();
    idle_inputs();
    push("ov_epc", 0, REG_EPC, 32'h0000_3020);
    push("ov_cause", 0, REG_CAUSE, 32'h8000_0030);
    push("ov_sr", 0, REG_SR, 32'h0000_0403);
    while (sb.size() > 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      A1 = e.a1; #1;
      obs = (e.kind == 0) ? DOut : (e.kind == 1) ? {31'b0, Req} : EPCOut;
      n_checks++;
      if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      else n_pass++;
    end
  endtask

  task automatic test_exl_mask();
    idle_inputs();
    ExcCodeIn = EXC_ADEL; PC = 32'h0000_5000; BDIn = 1'b0;
    push("exl_masks_exc", 1, 5'd0, 32'h0);
    while (sb.size() > 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      A1 = e.a1; #1;
      obs = (e.kind == 0) ? DOut : (e.kind == 1) ? {31'b0, Req} : EPCOut;
      n_checks++;
      if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      else n_pass++;
    end
    tick();
    ExcCodeIn = 5'd0;
    push("exl_cause_kept", 0, REG_CAUSE, 32'h8000_0030);
    push("exl_epc_kept", 0, REG_EPC, 32'h0000_3020);
    while (sb.size() > 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      A1 = e.a1; #1;
      obs = (e.kind == 0) ? DOut : (e.kind == 1) ? {31'b0, Req} : EPCOut;
      n_checks++;
      if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      else n_pass++;
    end
    // mtc0 while in the handler (no Req): EPC and SR writable, Cause not
    WE = 1'b1; A2 = REG_EPC; DIn = 32'h1234_5678;
    tick();
    A2 = REG_CAUSE; DIn = 32'hFFFF_FFFF;
    tick();
    WE = 1'b0;
    push("mtc0_epc", 0, REG_EPC, 32'h1234_5678);
    push("mtc0_cause_ignored", 0, REG_CAUSE, 32'h8000_0030);
    while (sb.size() > 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      A1 = e.a1; #1;
      obs = (e.kind == 0) ? DOut : (e.kind == 1) ? {31'b0, Req} : EPCOut;
      n_checks++;
      if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      else n_pass++;
    end
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    HWInt = 6'b000001;
    push("clr_sr", 0, REG_SR, 32'h0000_0401);
    push("pending_int_req", 1, 5'd0, 32'h1);
    while (sb.size() > 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      A1 = e.a1; #1;
      obs = (e.kind == 0) ? DOut : (e.kind == 1) ? {31'b0, Req} : EPCOut;
      n_checks++;
      if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      else n_pass++;
    end
  endtask

  task automatic test_priority();
    // interrupt beats exception code; mtc0 in the Req cycle is dropped
    ExcCodeIn = EXC_RI; PC = 32'h0000_3044; BDIn = 1'b0;
    WE = 1'b1; A2 = REG_EPC; DIn = 32'hDEAD_0000;
    tick();
    idle_inputs();
    push("prio_cause_int", 0, REG_CAUSE, 32'h0000_0400);
    push("prio_epc_fault_pc", 0, REG_EPC, 32'h0000_3044);
    push("prio_sr", 0, REG_SR, 32'h0000_0403);
    while (sb.size() > 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      A1 = e.a1; #1;
      obs = (e.kind == 0) ? DOut : (e.kind == 1) ? {31'b0, Req} : EPCOut;
      n_checks++;
      if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      else n_pass++;
    end
    EXLClr = 1'b1;
    tick();
    // Req with eret in the same cycle: EXL stays set, EPC captured, PC aligned
    ExcCodeIn = EXC_ADES; PC = 32'h0000_3001; EXLClr = 1'b1;
    tick();
    idle_inputs();
    push("req_eret_sr", 0, REG_SR, 32'h0000_0403);
    push("req_eret_epc", 2, 5'd0, 32'h0000_3000);
    push("req_eret_cause", 0, REG_CAUSE, 32'h0000_0014);
    while (sb.size() > 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      A1 = e.a1; #1;
      obs = (e.kind == 0) ? DOut : (e.kind == 1) ? {31'b0, Req} : EPCOut;
      n_checks++;
      if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      else n_pass++;
    end
    // delay slot at PC 0: EPC wraps
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0; ExcCodeIn = EXC_SYSCALL; BDIn = 1'b1; PC = 32'h0000_0002;
    tick();
    idle_inputs();
    push("bd_wrap_epc", 0, REG_EPC, 32'hFFFF_FFFC);
    push("bd_wrap_cause", 0, REG_CAUSE, 32'h8000_0020);
    while (sb.size() > 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      A1 = e.a1; #1;
      obs = (e.kind == 0) ? DOut : (e.kind == 1) ? {31'b0, Req} : EPCOut;
      n_checks++;
      if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      else n_pass++;
    end
    // full SR write (EXL=1 so no Req): only IM/EXL/IE stick
    WE = 1'b1; A2 = REG_SR; DIn = 32'hFFFF_FFFF;
    tick();
    WE = 1'b0;
    push("sr_mask_bits", 0, REG_SR, 32'h0000_FC03);
    while (sb.size() > 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      A1 = e.a1; #1;
      obs = (e.kind == 0) ? DOut : (e.kind == 1) ? {31'b0, Req} : EPCOut;
      n_checks++;
      if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      else n_pass++;
    end
  endtask

  task automatic test_reset_priority();
    idle_inputs();
    WE = 1'b1; A2 = REG_SR; DIn = 32'h0000_0401;
    tick();
    WE = 1'b0; HWInt = 6'b000001; PC = 32'h0000_3100;
    push("pre_reset_req", 1, 5'd0, 32'h1);
    while (sb.size() > 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      A1 = e.a1; #1;
      obs = (e.kind == 0) ? DOut : (e.kind == 1) ? {31'b0, Req} : EPCOut;
      n_checks++;
      if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      else n_pass++;
    end
    reset = 1'b1; WE = 1'b1; A2 = REG_EPC; DIn = 32'hDEAD_0000;
    tick();
    idle_inputs();
    push("rr_sr", 0, REG_SR, 32'h0);
    push("rr_cause", 0, REG_CAUSE, 32'h0);
    push("rr_epc", 2, 5'd0, 32'h0);
    push("rr_prid", 0, REG_PRID, PRID);
    push("rr_req", 1, 5'd0, 32'h0);
    while (sb.size() > 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      A1 = e.a1; #1;
      obs = (e.kind == 0) ? DOut : (e.kind == 1) ? {31'b0, Req} : EPCOut;
      n_checks++;
      if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      else n_pass++;
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #5;
    test_reset();
    test_interrupt();
    test_exception_bd();
    test_exl_mask();
    test_priority();
    test_reset_priority();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
